// File: rtl/rand_dir_picker_if.sv
// Request/response bundle between the maze FSM (master) and rand_dir_picker (slave).
// stat_picks/stat_rejects exist only when RAND_DIR_PICKER_STATS_EN is defined.
interface rand_dir_picker_if #(
    parameter int DIR_W = 2
);
    localparam int N = 1 << DIR_W;

    logic [31:0]      rand_word;
    logic             req_valid;
    logic             req_ready;
    logic [N-1:0]     req_mask;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [DIR_W-1:0] rsp_value;
    logic             rsp_empty;
    logic             rsp_fallback;
`ifdef RAND_DIR_PICKER_STATS_EN
    logic [15:0]      stat_picks;
    logic [15:0]      stat_rejects;

    modport master (
        output rand_word, req_valid, req_mask, rsp_ready,
        input  req_ready, rsp_valid, rsp_value, rsp_empty, rsp_fallback,
        input  stat_picks, stat_rejects
    );

    modport slave (
        input  rand_word, req_valid, req_mask, rsp_ready,
        output req_ready, rsp_valid, rsp_value, rsp_empty, rsp_fallback,
        output stat_picks, stat_rejects
    );
`else
    modport master (
        output rand_word, req_valid, req_mask, rsp_ready,
        input  req_ready, rsp_valid, rsp_value, rsp_empty, rsp_fallback
    );

    modport slave (
        input  rand_word, req_valid, req_mask, rsp_ready,
        output req_ready, rsp_valid, rsp_value, rsp_empty, rsp_fallback
    );
`endif
endinterface

// File: rtl/rand_dir_picker.sv
// Picks one set bit of a candidate mask uniformly by rejection sampling DIR_W-bit chunks of a random word.
// Optional saturating pick/reject counters are built when RAND_DIR_PICKER_STATS_EN is defined.
module rand_dir_picker #(
    parameter int DIR_W     = 2,
    parameter int MAX_TRIES = 64
) (
    input  logic              clk,
    input  logic              rst,
    rand_dir_picker_if.slave  bus
);
    localparam int N      = 1 << DIR_W;
    localparam int CHUNKS = 32 / DIR_W;
    localparam logic [7:0] TRY_LAST   = 8'(MAX_TRIES - 1);
    localparam logic [5:0] CHUNK_LAST = 6'(CHUNKS - 1);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        DRAW,
        DONE
    } state_t;

    state_t           state_q;
    logic [N-1:0]     mask_q;
    logic [31:0]      buf_q;
    logic [5:0]       chunk_q;
    logic [7:0]       tries_q;
    logic [DIR_W-1:0] value_q;
    logic             empty_q;
    logic             fallback_q;
    logic             valid_q;
    logic             ready_q;

    logic [DIR_W-1:0] chunkIdx_d;
    logic [DIR_W-1:0] lowestSet_d;
    logic             hit_d;

    // Scanning from the top down leaves the lowest set index as the final assignment.
    always_comb begin
        chunkIdx_d  = buf_q[DIR_W-1:0];
        hit_d       = mask_q[chunkIdx_d];
        lowestSet_d = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (mask_q[i]) begin
                lowestSet_d = DIR_W'(i);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= IDLE;
            mask_q     <= '0;
            buf_q      <= '0;
            chunk_q    <= '0;
            tries_q    <= '0;
            value_q    <= '0;
            empty_q    <= 1'b0;
            fallback_q <= 1'b0;
            valid_q    <= 1'b0;
            ready_q    <= 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.req_valid) begin
                        mask_q     <= bus.req_mask;
                        tries_q    <= '0;
                        value_q    <= '0;
                        fallback_q <= 1'b0;
                        ready_q    <= 1'b0;
                        if (bus.req_mask == '0) begin
                            empty_q <= 1'b1;
                            valid_q <= 1'b1;
                            state_q <= DONE;
                        end else begin
                            empty_q <= 1'b0;
                            state_q <= LOAD;
                        end
                    end
                end
                LOAD: begin
                    buf_q   <= bus.rand_word;
                    chunk_q <= '0;
                    state_q <= DRAW;
                end
                DRAW: begin
                    tries_q <= tries_q + 8'd1;
                    // A hit on the final allowed try still wins over the fallback.
                    if (hit_d) begin
                        value_q <= chunkIdx_d;
                        valid_q <= 1'b1;
                        state_q <= DONE;
                    end else if (tries_q == TRY_LAST) begin
                        value_q    <= lowestSet_d;
                        fallback_q <= 1'b1;
                        valid_q    <= 1'b1;
                        state_q    <= DONE;
                    end else if (chunk_q == CHUNK_LAST) begin
                        state_q <= LOAD;
                    end else begin
                        buf_q   <= buf_q >> DIR_W;
                        chunk_q <= chunk_q + 6'd1;
                    end
                end
                DONE: begin
                    if (bus.rsp_ready) begin
                        valid_q <= 1'b0;
                        ready_q <= 1'b1;
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.req_ready    = ready_q;
    assign bus.rsp_valid    = valid_q;
    assign bus.rsp_value    = value_q;
    assign bus.rsp_empty    = empty_q;
    assign bus.rsp_fallback = fallback_q;

`ifdef RAND_DIR_PICKER_STATS_EN
    logic [15:0] picks_q;
    logic [15:0] rejects_q;

    // The fallback draw also missed the mask, so it counts as a reject.
    always_ff @(posedge clk) begin
        if (!rst) begin
            picks_q   <= '0;
            rejects_q <= '0;
        end else begin
            if (state_q == DONE && bus.rsp_ready && picks_q != 16'hFFFF) begin
                picks_q <= picks_q + 16'd1;
            end
            if (state_q == DRAW && !hit_d && rejects_q != 16'hFFFF) begin
                rejects_q <= rejects_q + 16'd1;
            end
        end
    end

    assign bus.stat_picks   = picks_q;
    assign bus.stat_rejects = rejects_q;
`endif

endmodule

// File: tb/tb_rand_dir_picker.sv
// Self-checking bench for rand_dir_picker: directed cases plus randomized requests against a pick-level model.
// Stat counters are checked when RAND_DIR_PICKER_STATS_EN is defined.
module tb_rand_dir_picker;
    localparam int DIR_W     = 2;
    localparam int MAX_TRIES = 64;
    localparam int N         = 1 << DIR_W;
    localparam int CHUNKS    = 32 / DIR_W;
    localparam int BOUND     = 400;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    rand_dir_picker_if #(.DIR_W(DIR_W)) bus ();

    rand_dir_picker #(.DIR_W(DIR_W), .MAX_TRIES(MAX_TRIES)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int total = 0;
    int bad   = 0;

    logic [31:0] words [BOUND];
    int expPicks   = 0;
    int expRejects = 0;

    logic [DIR_W-1:0] obsValue;
    logic             obsEmpty;
    logic             obsFallback;
    int               obsLatency;

    logic [DIR_W-1:0] modValue;
    logic             modEmpty;
    logic             modFallback;
    int               modLatency;
    int               modRejects;

    // Walks the draw sequence: cycle 1 is the first LOAD, each draw and each refill costs one cycle.
    function automatic void runModel(input logic [N-1:0] mask);
        int t;
        int tries;
        int c;
        int lowest;
        logic [31:0] w;
        modEmpty    = 1'b0;
        modFallback = 1'b0;
        modValue    = '0;
        modRejects  = 0;
        modLatency  = 0;
        if (mask == '0) begin
            modEmpty   = 1'b1;
            modLatency = 1;
            return;
        end
        lowest = 0;
        for (int i = N - 1; i >= 0; i--) if (mask[i]) lowest = i;
        t     = 1;
        tries = 0;
        for (int guard = 0; guard < BOUND; guard++) begin
            w = words[t];
            t++;
            for (int k = 0; k < CHUNKS; k++) begin
                c = int'((w >> (k * DIR_W)) & 32'(N - 1));
                t++;
                tries++;
                if (mask[c]) begin
                    modValue   = DIR_W'(c);
                    modLatency = t;
                    return;
                end
                modRejects++;
                if (tries == MAX_TRIES) begin
                    modValue    = DIR_W'(lowest);
                    modFallback = 1'b1;
                    modLatency  = t;
                    return;
                end
            end
        end
    endfunction

    // Issues one request and follows rand_word = words[cycle since accept] until rsp_valid or the bound.
    task automatic applyStimulus(input logic [N-1:0] mask);
        int cyc;
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_mask  = mask;
        bus.rand_word = words[0];
        bus.rsp_ready = 1'b0;
        cyc = 0;
        while (!bus.req_ready && cyc < BOUND) begin
            @(negedge clk);
            cyc++;
        end
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 1'b0;
        bus.req_mask  = N'($urandom);
        cyc = 1;
        bus.rand_word = words[1];
        while (!bus.rsp_valid && cyc < BOUND - 1) begin
            @(negedge clk);
            cyc++;
            bus.rand_word = words[cyc];
        end
        obsValue    = bus.rsp_value;
        obsEmpty    = bus.rsp_empty;
        obsFallback = bus.rsp_fallback;
        obsLatency  = cyc;
    endtask

    task automatic finishResp(input int hold);
        for (int i = 0; i < hold; i++) @(negedge clk);
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        bus.rsp_ready = 1'b0;
        expPicks++;
    endtask

    task automatic fillWords(input logic [31:0] w);
        for (int i = 0; i < BOUND; i++) words[i] = w;
    endtask

    task automatic test_reset;
        rst = 1'b0;
        bus.req_valid = 1'b0;
        bus.req_mask  = '0;
        bus.rsp_ready = 1'b0;
        bus.rand_word = '0;
        repeat (3) @(negedge clk);
        total++; if (bus.req_ready !== 1'b1) begin bad++; $display("[TB] FAIL reset_req_ready got=%b exp=1", bus.req_ready); end
        total++; if (bus.rsp_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_rsp_valid got=%b exp=0", bus.rsp_valid); end
        total++; if (bus.rsp_value !== '0) begin bad++; $display("[TB] FAIL reset_rsp_value got=%0d exp=0", bus.rsp_value); end
        total++; if (bus.rsp_empty !== 1'b0) begin bad++; $display("[TB] FAIL reset_rsp_empty got=%b exp=0", bus.rsp_empty); end
        total++; if (bus.rsp_fallback !== 1'b0) begin bad++; $display("[TB] FAIL reset_rsp_fallback got=%b exp=0", bus.rsp_fallback); end
`ifdef RAND_DIR_PICKER_STATS_EN
        total++; if (bus.stat_picks !== 16'd0) begin bad++; $display("[TB] FAIL reset_stat_picks got=%0d exp=0", bus.stat_picks); end
        total++; if (bus.stat_rejects !== 16'd0) begin bad++; $display("[TB] FAIL reset_stat_rejects got=%0d exp=0", bus.stat_rejects); end
`endif
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_best_case;
        fillWords(32'h0000_0002);
        applyStimulus(4'b1111);
        total++; if (obsValue !== 2'd2) begin bad++; $display("[TB] FAIL best_value got=%0d exp=2", obsValue); end
        total++; if (obsFallback !== 1'b0) begin bad++; $display("[TB] FAIL best_fallback got=%b exp=0", obsFallback); end
        total++; if (obsEmpty !== 1'b0) begin bad++; $display("[TB] FAIL best_empty got=%b exp=0", obsEmpty); end
        total++; if (obsLatency !== 3) begin bad++; $display("[TB] FAIL best_latency got=%0d exp=3", obsLatency); end
        finishResp(0);
        total++; if (bus.req_ready !== 1'b1) begin bad++; $display("[TB] FAIL best_ready_after got=%b exp=1", bus.req_ready); end
    endtask

    task automatic test_rejects;
        fillWords(32'h0000_00C5);
        applyStimulus(4'b1000);
        expRejects += 3;
        total++; if (obsValue !== 2'd3) begin bad++; $display("[TB] FAIL rej_value got=%0d exp=3", obsValue); end
        total++; if (obsLatency !== 6) begin bad++; $display("[TB] FAIL rej_latency got=%0d exp=6", obsLatency); end
        total++; if (obsFallback !== 1'b0) begin bad++; $display("[TB] FAIL rej_fallback got=%b exp=0", obsFallback); end
        finishResp(1);
`ifdef RAND_DIR_PICKER_STATS_EN
        total++; if (bus.stat_rejects !== 16'(expRejects)) begin bad++; $display("[TB] FAIL rej_stat_rejects got=%0d exp=%0d", bus.stat_rejects, expRejects); end
        total++; if (bus.stat_picks !== 16'(expPicks)) begin bad++; $display("[TB] FAIL rej_stat_picks got=%0d exp=%0d", bus.stat_picks, expPicks); end
`endif
    endtask

    task automatic test_empty;
        fillWords(32'hFFFF_FFFF);
        applyStimulus(4'b0000);
        total++; if (obsEmpty !== 1'b1) begin bad++; $display("[TB] FAIL empty_flag got=%b exp=1", obsEmpty); end
        total++; if (obsValue !== 2'd0) begin bad++; $display("[TB] FAIL empty_value got=%0d exp=0", obsValue); end
        total++; if (obsFallback !== 1'b0) begin bad++; $display("[TB] FAIL empty_fallback got=%b exp=0", obsFallback); end
        total++; if (obsLatency !== 1) begin bad++; $display("[TB] FAIL empty_latency got=%0d exp=1", obsLatency); end
        finishResp(0);
    endtask

    task automatic test_fallback;
        fillWords(32'h0000_0000);
        applyStimulus(4'b0100);
        expRejects += MAX_TRIES;
        total++; if (obsValue !== 2'd2) begin bad++; $display("[TB] FAIL fb_value got=%0d exp=2", obsValue); end
        total++; if (obsFallback !== 1'b1) begin bad++; $display("[TB] FAIL fb_flag got=%b exp=1", obsFallback); end
        total++; if (obsEmpty !== 1'b0) begin bad++; $display("[TB] FAIL fb_empty got=%b exp=0", obsEmpty); end
        total++; if (obsLatency !== 69) begin bad++; $display("[TB] FAIL fb_latency got=%0d exp=69", obsLatency); end
        finishResp(0);
`ifdef RAND_DIR_PICKER_STATS_EN
        total++; if (bus.stat_rejects !== 16'(expRejects)) begin bad++; $display("[TB] FAIL fb_stat_rejects got=%0d exp=%0d", bus.stat_rejects, expRejects); end
`endif
    endtask

    task automatic test_hold;
        logic [N-1:0] mask;
        for (int i = 0; i < BOUND; i++) words[i] = $urandom;
        mask = N'($urandom) | 4'b0010;
        runModel(mask);
        applyStimulus(mask);
        expRejects += modRejects;
        for (int h = 0; h < 5; h++) begin
            @(negedge clk);
            total++; if (bus.rsp_valid !== 1'b1) begin bad++; $display("[TB] FAIL hold_valid cyc=%0d got=%b exp=1", h, bus.rsp_valid); end
            total++; if (bus.rsp_value !== modValue) begin bad++; $display("[TB] FAIL hold_value cyc=%0d got=%0d exp=%0d", h, bus.rsp_value, modValue); end
            total++; if (bus.rsp_fallback !== modFallback || bus.rsp_empty !== 1'b0) begin bad++; $display("[TB] FAIL hold_flags cyc=%0d got=%b%b exp=%b0", h, bus.rsp_fallback, bus.rsp_empty, modFallback); end
            total++; if (bus.req_ready !== 1'b0) begin bad++; $display("[TB] FAIL hold_ready cyc=%0d got=%b exp=0", h, bus.req_ready); end
        end
        finishResp(0);
        total++; if (bus.rsp_valid !== 1'b0) begin bad++; $display("[TB] FAIL hold_valid_drop got=%b exp=0", bus.rsp_valid); end
        total++; if (bus.req_ready !== 1'b1) begin bad++; $display("[TB] FAIL hold_ready_back got=%b exp=1", bus.req_ready); end
    endtask

    task automatic test_mid_reset;
        logic [N-1:0] mask;
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_mask  = 4'b1000;
        bus.rand_word = '0;
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        expPicks   = 0;
        expRejects = 0;
        total++; if (bus.rsp_valid !== 1'b0) begin bad++; $display("[TB] FAIL mrst_valid got=%b exp=0", bus.rsp_valid); end
        total++; if (bus.req_ready !== 1'b1) begin bad++; $display("[TB] FAIL mrst_ready got=%b exp=1", bus.req_ready); end
        total++; if (bus.rsp_fallback !== 1'b0 || bus.rsp_empty !== 1'b0) begin bad++; $display("[TB] FAIL mrst_flags got=%b%b exp=00", bus.rsp_fallback, bus.rsp_empty); end
`ifdef RAND_DIR_PICKER_STATS_EN
        total++; if (bus.stat_rejects !== 16'd0) begin bad++; $display("[TB] FAIL mrst_stat_rejects got=%0d exp=0", bus.stat_rejects); end
`endif
        rst = 1'b1;
        for (int i = 0; i < BOUND; i++) words[i] = $urandom;
        mask = N'($urandom) | 4'b0001;
        runModel(mask);
        applyStimulus(mask);
        expRejects += modRejects;
        total++; if (obsValue !== modValue) begin bad++; $display("[TB] FAIL mrst_after_value got=%0d exp=%0d", obsValue, modValue); end
        total++; if (obsLatency !== modLatency) begin bad++; $display("[TB] FAIL mrst_after_latency got=%0d exp=%0d", obsLatency, modLatency); end
        finishResp(0);
    endtask

    task automatic test_random;
        logic [N-1:0] mask;
        for (int it = 0; it < 30; it++) begin
            for (int i = 0; i < BOUND; i++) begin
                words[i] = (it % 5 == 4) ? ($urandom & 32'h1111_0000) : $urandom;
            end
            mask = N'($urandom);
            if (it % 7 == 3) mask = '0;
            if (it % 5 == 4) mask = 4'b0110;
            runModel(mask);
            applyStimulus(mask);
            expRejects += modRejects;
            total++; if (obsValue !== modValue) begin bad++; $display("[TB] FAIL rnd_value it=%0d mask=%b got=%0d exp=%0d", it, mask, obsValue, modValue); end
            total++; if (obsEmpty !== modEmpty) begin bad++; $display("[TB] FAIL rnd_empty it=%0d got=%b exp=%b", it, obsEmpty, modEmpty); end
            total++; if (obsFallback !== modFallback) begin bad++; $display("[TB] FAIL rnd_fallback it=%0d got=%b exp=%b", it, obsFallback, modFallback); end
            total++; if (obsLatency !== modLatency) begin bad++; $display("[TB] FAIL rnd_latency it=%0d got=%0d exp=%0d", it, obsLatency, modLatency); end
            finishResp(int'($urandom_range(0, 3)));
        end
`ifdef RAND_DIR_PICKER_STATS_EN
        total++; if (bus.stat_picks !== 16'(expPicks)) begin bad++; $display("[TB] FAIL rnd_stat_picks got=%0d exp=%0d", bus.stat_picks, expPicks); end
        total++; if (bus.stat_rejects !== 16'(expRejects)) begin bad++; $display("[TB] FAIL rnd_stat_rejects got=%0d exp=%0d", bus.stat_rejects, expRejects); end
`endif
    endtask

    initial begin
        test_reset();
        test_best_case();
        test_rejects();
        test_empty();
        test_fallback();
        test_hold();
        test_mid_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
